ifetch_pc_unit: RTL and testbench

- Fetch-stage controller that sits directly upstream of the byte-addressed instruction memory in the single-cycle MIPS core.
- Owns the program counter and drives the instruction-memory address.
- Returns the fetched word to decode, and selects the next PC from sequential, branch, jump and jr sources.
- Detects the halt opcode, out-of-range fetches and stalls, and keeps a retired-fetch counter.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_next_pc.sv | 25 ++
 rtl/ifetch_pc_unit.sv | 90 +++++++++
 tb/tb_ifetch_pc_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared encodings and helpers for the fetch-stage PC unit
package ifetch_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// rtl/ifetch_next_pc.sv - combinational next-PC mux with branch/jump target arithmetic
module ifetch_next_pc
  import ifetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [31:0] jr_target,
  input  logic [25:0] jump_index,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SEQ: next_pc = pc_plus4;
      PC_BR:  if (branch_taken) next_pc = pc_plus4 + (imm_ext << 2);
      PC_J:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      PC_JR:  next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/ifetch_pc_unit.sv
// rtl/ifetch_pc_unit.sv - fetch-stage PC/FSM/counter; IFETCH_ALIGN_CHECK_EN enables misaligned-target trapping
module ifetch_pc_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_BYTES  = 128,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [31:0] jr_target,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        addr_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  state_t      state;
  logic [31:0] raw_pc;
  logic [31:0] load_pc;
  logic        bad_pc;
  logic        halt_op;

  assign inst_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign instr     = (state == RUN) ? inst_data : NOP_INSTR;
  assign halt_op   = (instr[31:26] == HALT_OPCODE);

  ifetch_next_pc u_next_pc (
    .pc_plus4     (pc_plus4),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .jr_target    (jr_target),
    .jump_index   (instr[25:0]),
    .next_pc      (raw_pc)
  );

`ifdef IFETCH_ALIGN_CHECK_EN
  assign load_pc = raw_pc;
  assign bad_pc  = (raw_pc > PC_MAX) || (raw_pc[1:0] != 2'b00);
`else
  // Only jr can misalign; silently word-align it instead of trapping.
  assign load_pc = raw_pc & ~32'h0000_0003;
  assign bad_pc  = (load_pc > PC_MAX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= BOOT;
      halted      <= 1'b0;
      addr_err    <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          // Priority: stall, then halt opcode, then target checks, then advance.
          if (!stall) begin
            if (halt_op) begin
              state       <= HALTED;
              halted      <= 1'b1;
              fetch_count <= sat_inc(fetch_count);
            end else if (bad_pc) begin
              state    <= HALTED;
              halted   <= 1'b1;
              addr_err <= 1'b1;
            end else begin
              pc          <= load_pc;
              fetch_count <= sat_inc(fetch_count);
            end
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// tb/tb_ifetch_pc_unit.sv - directed self-checking bench for ifetch_pc_unit
module tb_ifetch_pc_unit;

  localparam logic [31:0] ADD  = 32'h0109_5020;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] imm_ext;
  logic [31:0] jr_target;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        addr_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [32];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign inst_data = mem[inst_addr[6:2]];

  ifetch_pc_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .jr_target    (jr_target),
    .inst_addr    (inst_addr),
    .inst_data    (inst_data),
    .instr        (instr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .addr_err     (addr_err),
    .fetch_count  (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    stall = 1'b0;
    pc_src = 2'b00;
    branch_taken = 1'b0;
    imm_ext = 32'h0;
    jr_target = 32'h0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = ADD;
    mem[3] = HALT;

    // Sequential run into halt word at 12
    restart();
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_addr_err", {31'h0, addr_err}, 32'h0);
    check("rst_instr", instr, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("boot_instr", instr, 32'h0);
    check("boot_pc", pc, 32'h0);
    step();
    check("run0_pc", pc, 32'h0);
    check("run0_instr", instr, ADD);
    step(); check("seq_pc4", pc, 32'h4);
    step(); check("seq_pc8", pc, 32'h8);
    step(); check("seq_pc12", pc, 32'hC);
    check("seq_not_halted", {31'h0, halted}, 32'h0);
    check("seq_plus4", pc_plus4, 32'h10);
    step();
    check("seq_halted", {31'h0, halted}, 32'h1);
    check("seq_count", fetch_count, 32'h4);
    check("seq_pc_hold", pc, 32'hC);
    step();
    check("halt_pc_frozen", pc, 32'hC);
    check("halt_instr", instr, 32'h0);
    check("halt_count_frozen", fetch_count, 32'h4);

    // Branch, jump, jr
    mem[3] = ADD;
    mem[5] = 32'h0800_0010;
    mem[10] = HALT;
    restart();
    step(); step(); step(); step();
    check("br_start_pc", pc, 32'h10);
    pc_src = 2'b01; branch_taken = 1'b1; imm_ext = 32'hFFFF_FFFD;
    step(); check("br_taken_pc", pc, 32'h8);
    pc_src = 2'b00; branch_taken = 1'b0;
    step(); step();
    check("br_back_pc", pc, 32'h10);
    pc_src = 2'b01;
    step(); check("br_not_taken_pc", pc, 32'h14);
    pc_src = 2'b10;
    step(); check("jump_pc", pc, 32'h40);
    pc_src = 2'b11; jr_target = 32'h24;
    step(); check("jr_pc", pc, 32'h24);
    check("jr_count", fetch_count, 32'd10);

    // Stall overrides halt at 0x28
    pc_src = 2'b00;
    step(); check("stall_start_pc", pc, 32'h28);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h28);
      check("stall_count", fetch_count, 32'd11);
      check("stall_halted", {31'h0, halted}, 32'h0);
    end
    stall = 1'b0;
    step();
    check("post_stall_halted", {31'h0, halted}, 32'h1);
    check("post_stall_count", fetch_count, 32'd12);
    check("post_stall_pc", pc, 32'h28);
    stall = 1'b1;
    step();
    check("halted_ignores_stall", {31'h0, halted}, 32'h1);

    // Out-of-range jr target
    restart();
    pc_src = 2'b11; jr_target = 32'h80;
    step();
    check("range_addr_err", {31'h0, addr_err}, 32'h1);
    check("range_halted", {31'h0, halted}, 32'h1);
    check("range_pc", pc, 32'h0);
    check("range_count", fetch_count, 32'h0);

    // Misaligned jr target
    restart();
    pc_src = 2'b11; jr_target = 32'h0A;
    step();
`ifdef IFETCH_ALIGN_CHECK_EN
    check("align_addr_err", {31'h0, addr_err}, 32'h1);
    check("align_pc", pc, 32'h0);
`else
    check("align_addr_err", {31'h0, addr_err}, 32'h0);
    check("align_pc", pc, 32'h8);
`endif

    // Async reset mid-run in RUN at 0x20
    restart();
    for (int i = 0; i < 8; i++) step();
    check("mid_pc", pc, 32'h20);
    #2 rst_n = 1'b0;
    #1;
    check("async_run_pc", pc, 32'h0);
    check("async_run_count", fetch_count, 32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("async_boot_instr", instr, 32'h0);
    step();
    check("async_boot_pc", pc, 32'h0);
    check("async_boot_count", fetch_count, 32'h0);

    // Async reset while HALTED at 0x20
    mem[8] = HALT;
    restart();
    pc_src = 2'b11; jr_target = 32'h80;
    step();
    pc_src = 2'b00;
    restart();
    for (int i = 0; i < 9; i++) step();
    check("halt20_halted", {31'h0, halted}, 32'h1);
    check("halt20_pc", pc, 32'h20);
    #2 rst_n = 1'b0;
    #1;
    check("async_halt_pc", pc, 32'h0);
    check("async_halt_count", fetch_count, 32'h0);
    check("async_halt_halted", {31'h0, halted}, 32'h0);
    check("async_halt_addr_err", {31'h0, addr_err}, 32'h0);
    #1 rst_n = 1'b1;
    step();
    check("async_halt_boot_pc", pc, 32'h0);
    step();
    check("async_halt_run_pc", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
